ledr_write_arbiter: RTL and testbench

- Avalon-MM master that shares the 10-bit LEDR PIO output register between two requesters, for example the accelerator progress indicator and the software status path.
- Round-robin arbitration between the requesters.
- Each grant performs one write of the requested pattern to PIO register 0, then a read-back verify cycle.
- After each update the winning pattern stays on the LEDs for a minimum number of cycles before another update is allowed.
- Sits between the requester logic and the PIO slave port s1.

---
 rtl/ledr_write_arbiter.sv | 157 +++++++++++++++
 tb/tb_ledr_write_arbiter.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/ledr_write_arbiter.sv
// ledr_write_arbiter: round-robin Avalon-MM master sharing the LEDR PIO register
// between two requesters. Each grant writes the pattern, reads it back to verify,
// then holds the LEDs for HOLD_CYCLES before the next update is allowed.
module ledr_write_arbiter #(
    parameter int unsigned HOLD_CYCLES = 4,
    parameter int unsigned HOLD_W      = 16
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [1:0]  req,
    input  logic [9:0]  pattern0,
    input  logic [9:0]  pattern1,
    output logic [1:0]  ack,
    input  logic        err_clr,
    output logic [1:0]  pio_address,
    output logic        pio_chipselect,
    output logic        pio_write_n,
    output logic [31:0] pio_writedata,
    input  logic [31:0] pio_readdata,
    output logic        busy,
    output logic        last_grant,
    output logic        verify_err
);

    localparam int unsigned PAT_W  = 10;
    localparam int unsigned DATA_W = 32;
    localparam int unsigned PAD_W  = DATA_W - PAT_W;
    localparam logic [HOLD_W-1:0] HOLD_LOAD =
        (HOLD_CYCLES > 0) ? HOLD_W'(HOLD_CYCLES - 1) : '0;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_WRITE  = 2'd1,
        ST_VERIFY = 2'd2,
        ST_HOLD   = 2'd3
    } state_t;

    state_t              state_q;
    state_t              state_d;
    logic [HOLD_W-1:0]   cnt_q;
    logic [HOLD_W-1:0]   cnt_d;
    logic [PAT_W-1:0]    pat_q;
    logic [PAT_W-1:0]    pat_d;
    logic                grant_d;
    logic                mismatch_c;

    logic                cs_d;
    logic                write_n_d;
    logic [DATA_W-1:0]   writedata_d;
    logic [1:0]          ack_d;
    logic                busy_d;
    logic                err_d;

    // Upper read-back bits carry no LED state and are deliberately ignored.
    logic                unused_rd_hi;
    assign unused_rd_hi = ^pio_readdata[DATA_W-1:PAT_W];

    // State register plus datapath registers (hold counter, latched pattern, fairness).
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= ST_IDLE;
            cnt_q      <= '0;
            pat_q      <= '0;
            last_grant <= 1'b1;
            verify_err <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            pat_q      <= pat_d;
            last_grant <= grant_d;
            verify_err <= err_d;
        end
    end

    // Registered bus and handshake outputs, driven from the next-state decode.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ack            <= '0;
            pio_address    <= '0;
            pio_chipselect <= 1'b0;
            pio_write_n    <= 1'b1;
            pio_writedata  <= '0;
            busy           <= 1'b0;
        end else begin
            ack            <= ack_d;
            pio_address    <= '0;
            pio_chipselect <= cs_d;
            pio_write_n    <= write_n_d;
            pio_writedata  <= writedata_d;
            busy           <= busy_d;
        end
    end

    // Next-state logic: round-robin grant in IDLE, fixed WRITE/VERIFY, counted HOLD.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        pat_d   = pat_q;
        grant_d = last_grant;
        unique case (state_q)
            ST_IDLE: begin
                if (|req) begin
                    state_d = ST_WRITE;
                    grant_d = (&req) ? ~last_grant : req[1];
                    pat_d   = grant_d ? pattern1 : pattern0;
                end
            end
            ST_WRITE: begin
                state_d = ST_VERIFY;
            end
            ST_VERIFY: begin
                if (HOLD_CYCLES > 0) begin
                    state_d = ST_HOLD;
                    cnt_d   = HOLD_LOAD;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_HOLD: begin
                if (cnt_q == '0) begin
                    state_d = ST_IDLE;
                end else begin
                    cnt_d = cnt_q - HOLD_W'(1);
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Output decode for the upcoming state; a read-back mismatch beats err_clr.
    always_comb begin
        cs_d        = 1'b0;
        write_n_d   = 1'b1;
        writedata_d = '0;
        ack_d       = '0;
        busy_d      = (state_d != ST_IDLE);
        mismatch_c  = (state_q == ST_VERIFY) && (pio_readdata[PAT_W-1:0] != pat_q);
        err_d       = verify_err;
        if (state_d == ST_WRITE) begin
            cs_d        = 1'b1;
            write_n_d   = 1'b0;
            writedata_d = {PAD_W'(0), pat_d};
        end
        if (state_d == ST_VERIFY) begin
            cs_d           = 1'b1;
            ack_d[grant_d] = 1'b1;
        end
        if (mismatch_c) begin
            err_d = 1'b1;
        end else if (err_clr) begin
            err_d = 1'b0;
        end
    end

endmodule

// File: tb/tb_ledr_write_arbiter.sv
// Directed bench for ledr_write_arbiter: HOLD_CYCLES=4 instance plus a HOLD_CYCLES=0 instance.
module tb_ledr_write_arbiter;

    logic        clk;
    logic        reset_n;

    // HOLD_CYCLES=4 instance signals
    logic [1:0]  req;
    logic [9:0]  pattern0;
    logic [9:0]  pattern1;
    logic        err_clr;
    logic [1:0]  ack;
    logic [1:0]  pio_address;
    logic        pio_chipselect;
    logic        pio_write_n;
    logic [31:0] pio_writedata;
    logic [31:0] pio_readdata;
    logic        busy;
    logic        last_grant;
    logic        verify_err;

    // HOLD_CYCLES=0 instance signals
    logic [1:0]  req_b;
    logic [9:0]  pattern0_b;
    logic [1:0]  ack_b;
    logic [1:0]  pio_address_b;
    logic        pio_chipselect_b;
    logic        pio_write_n_b;
    logic [31:0] pio_writedata_b;
    logic [31:0] pio_readdata_b;
    logic        busy_b;
    logic        last_grant_b;
    logic        verify_err_b;

    // PIO slave models
    logic [31:0] pio_reg;
    logic [31:0] pio_reg_b;
    logic        force_rd0;

    int tests_run;
    int tests_failed;

    ledr_write_arbiter #(.HOLD_CYCLES(4), .HOLD_W(16)) dut (
        .clk(clk), .reset_n(reset_n), .req(req), .pattern0(pattern0), .pattern1(pattern1),
        .ack(ack), .err_clr(err_clr), .pio_address(pio_address),
        .pio_chipselect(pio_chipselect), .pio_write_n(pio_write_n),
        .pio_writedata(pio_writedata), .pio_readdata(pio_readdata),
        .busy(busy), .last_grant(last_grant), .verify_err(verify_err)
    );

    ledr_write_arbiter #(.HOLD_CYCLES(0), .HOLD_W(16)) dut0 (
        .clk(clk), .reset_n(reset_n), .req(req_b), .pattern0(pattern0_b), .pattern1(10'h000),
        .ack(ack_b), .err_clr(1'b0), .pio_address(pio_address_b),
        .pio_chipselect(pio_chipselect_b), .pio_write_n(pio_write_n_b),
        .pio_writedata(pio_writedata_b), .pio_readdata(pio_readdata_b),
        .busy(busy_b), .last_grant(last_grant_b), .verify_err(verify_err_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (pio_chipselect && !pio_write_n) pio_reg <= pio_writedata;
        if (pio_chipselect_b && !pio_write_n_b) pio_reg_b <= pio_writedata_b;
    end
    assign pio_readdata   = force_rd0 ? 32'h0 : pio_reg;
    assign pio_readdata_b = pio_reg_b;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_idle(input string tag);
        int n;
        n = 0;
        while (busy && n < 50) begin
            step();
            n++;
        end
        check(tag, 32'(busy), 32'd0);
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        step();
        step();
        reset_n = 1'b1;
    endtask

    initial begin
        int n;
        logic [1:0] exp_ack;
        tests_run    = 0;
        tests_failed = 0;
        reset_n    = 1'b0;
        req        = 2'b00;
        pattern0   = 10'h000;
        pattern1   = 10'h000;
        err_clr    = 1'b0;
        req_b      = 2'b00;
        pattern0_b = 10'h3C3;
        force_rd0  = 1'b0;
        pio_reg    = 32'h0;
        pio_reg_b  = 32'h0;
        #2;
        step();
        step();
        reset_n = 1'b1;

        // Reset values
        check("rst_busy",   32'(busy), 32'd0);
        check("rst_lg",     32'(last_grant), 32'd1);
        check("rst_cs",     32'(pio_chipselect), 32'd0);
        check("rst_wn",     32'(pio_write_n), 32'd1);
        check("rst_ack",    32'(ack), 32'd0);
        check("rst_wd",     pio_writedata, 32'd0);
        check("rst_addr",   32'(pio_address), 32'd0);
        check("rst_err",    32'(verify_err), 32'd0);

        // Single request
        req      = 2'b01;
        pattern0 = 10'h2A5;
        step();
        check("single_cs",   32'(pio_chipselect), 32'd1);
        check("single_wn",   32'(pio_write_n), 32'd0);
        check("single_wd",   pio_writedata, 32'h000002A5);
        check("single_ack0", 32'(ack), 32'd0);
        check("single_lg",   32'(last_grant), 32'd0);
        step();
        check("single_ack",  32'(ack), 32'b01);
        check("single_vcs",  32'(pio_chipselect), 32'd1);
        check("single_vwn",  32'(pio_write_n), 32'd1);
        req = 2'b00;
        for (int i = 0; i < 4; i++) begin
            step();
            check("single_hold_busy", 32'(busy), 32'd1);
            check("single_hold_cs", 32'(pio_chipselect), 32'd0);
            check("single_hold_ack", 32'(ack), 32'd0);
        end
        step();
        check("single_idle_busy", 32'(busy), 32'd0);
        check("single_err", 32'(verify_err), 32'd0);

        // Fairness: both requesting continuously
        do_reset();
        req      = 2'b11;
        pattern0 = 10'h011;
        pattern1 = 10'h122;
        for (int k = 0; k < 4; k++) begin
            n = 0;
            do begin
                step();
                n++;
            end while (!(pio_chipselect && !pio_write_n) && n < 20);
            check("fair_grant", 32'(last_grant), 32'(k % 2));
            check("fair_wd", pio_writedata, (k % 2 == 0) ? 32'h011 : 32'h122);
            if (k > 0) check("fair_period", 32'(n), 32'd7);
        end
        check("fair_last", 32'(last_grant), 32'd1);
        req = 2'b00;
        wait_idle("fair_idle");

        // Pattern stability after grant
        req      = 2'b10;
        pattern1 = 10'h0F0;
        step();
        pattern1 = 10'h3FF;
        check("stab_wd", pio_writedata, 32'h000000F0);
        step();
        check("stab_ack", 32'(ack), 32'b10);
        req = 2'b00;
        step();
        check("stab_err", 32'(verify_err), 32'd0);
        wait_idle("stab_idle");

        // Verify failure, clear, and mismatch-over-clear priority
        force_rd0 = 1'b1;
        req       = 2'b01;
        pattern0  = 10'h001;
        step();
        step();
        check("verr_ack", 32'(ack), 32'b01);
        req = 2'b00;
        step();
        check("verr_set", 32'(verify_err), 32'd1);
        err_clr = 1'b1;
        step();
        err_clr = 1'b0;
        check("verr_clr", 32'(verify_err), 32'd0);
        wait_idle("verr_idle");
        req = 2'b01;
        step();
        step();
        err_clr = 1'b1;
        req     = 2'b00;
        step();
        err_clr = 1'b0;
        check("verr_prio", 32'(verify_err), 32'd1);
        force_rd0 = 1'b0;
        wait_idle("verr_idle2");
        err_clr = 1'b1;
        step();
        err_clr = 1'b0;

        // Reset during WRITE
        req      = 2'b10;
        pattern1 = 10'h155;
        step();
        check("mid_in_write", 32'(pio_chipselect && !pio_write_n), 32'd1);
        reset_n = 1'b0;
        #1;
        check("mid_cs",   32'(pio_chipselect), 32'd0);
        check("mid_wn",   32'(pio_write_n), 32'd1);
        check("mid_wd",   pio_writedata, 32'd0);
        check("mid_busy", 32'(busy), 32'd0);
        check("mid_lg",   32'(last_grant), 32'd1);
        check("mid_ack",  32'(ack), 32'd0);
        check("mid_err",  32'(verify_err), 32'd0);
        step();
        check("mid_held_ack", 32'(ack), 32'd0);
        reset_n = 1'b1;
        step();
        check("mid_re_wd", pio_writedata, 32'h00000155);
        check("mid_re_lg", 32'(last_grant), 32'd1);
        step();
        check("mid_re_ack", 32'(ack), 32'b10);
        req = 2'b00;
        wait_idle("mid_idle");

        // HOLD_CYCLES=0 instance: write every 3 cycles, chipselect only in WRITE/VERIFY
        req_b = 2'b01;
        for (int i = 0; i < 9; i++) begin
            step();
            exp_ack = (i % 3 == 1) ? 2'b01 : 2'b00;
            check("h0_cs",  32'(pio_chipselect_b), (i % 3 == 2) ? 32'd0 : 32'd1);
            check("h0_wn",  32'(pio_write_n_b), (i % 3 == 0) ? 32'd0 : 32'd1);
            check("h0_ack", 32'(ack_b), 32'(exp_ack));
            if (i % 3 == 0) check("h0_wd", pio_writedata_b, 32'h000003C3);
        end
        req_b = 2'b00;
        step();
        step();
        check("h0_idle", 32'(busy_b), 32'd0);
        check("h0_err", 32'(verify_err_b), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
